// File: rtl/dmac_pkg.sv
// rtl/dmac_pkg.sv - shared DMA channel types and constants
package dmac_pkg;

    localparam int DMAC_WORD_BYTES = 4;
    localparam int DMAC_LEN_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POP   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } dmac_state_t;

endpackage

// File: rtl/dmac_xfer_cnt.sv
// rtl/dmac_xfer_cnt.sv - loadable word down-counter with address incrementer
module dmac_xfer_cnt
    import dmac_pkg::*;
#(
    parameter int LEN_W     = DMAC_LEN_W,
    parameter int ADDR_STEP = DMAC_WORD_BYTES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [31:0]      i_load_addr,
    input  logic [LEN_W-1:0] i_load_len,
    input  logic             i_load_inc,
    input  logic             i_step,
    output logic [31:0]      o_addr,
    output logic [LEN_W-1:0] o_count,
    output logic             o_last
);

    localparam logic [31:0]      W_STEP = 32'(ADDR_STEP);
    localparam logic [LEN_W-1:0] W_ONE  = LEN_W'(1);

    logic [31:0]      r_addr;
    logic [LEN_W-1:0] r_count;
    logic             r_inc;
    logic             w_zero;

    assign w_zero  = (r_count == '0);
    assign o_addr  = r_addr;
    assign o_count = r_count;
    assign o_last  = (r_count == W_ONE);

    // a step on an exhausted count is ignored so the counter never wraps to all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_count <= '0;
            r_inc   <= 1'b0;
        end else if (i_load) begin
            r_addr  <= i_load_addr;
            r_count <= i_load_len;
            r_inc   <= i_load_inc;
        end else if (i_step && !w_zero) begin
            r_count <= r_count - W_ONE;
            if (r_inc) begin
                r_addr <= r_addr + W_STEP;
            end
        end
    end

endmodule

// File: rtl/dmac_wr_engine.sv
// rtl/dmac_wr_engine.sv - DMA destination engine: FIFO pop to bus write
module dmac_wr_engine
    import dmac_pkg::*;
#(
    parameter int LEN_W     = DMAC_LEN_W,
    parameter int ADDR_STEP = DMAC_WORD_BYTES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] xfer_len,
    input  logic             addr_inc,
    input  logic             fifo_empty,
    input  logic [31:0]      fifo_rdata,
    output logic             fifo_rd,
    output logic             fifo_clear,
    output logic             bus_req,
    output logic [31:0]      bus_addr,
    output logic [31:0]      bus_wdata,
    input  logic             bus_ack,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] remaining
);

    dmac_state_t r_state;
    dmac_state_t w_next;
    logic        r_bus_req;
    logic        r_fifo_clear;
    logic [31:0] r_wdata;
    logic        w_load;
    logic        w_step;
    logic        w_last;

    assign w_load = (r_state == ST_IDLE) && start && !abort && (xfer_len != '0);
    // an ack coinciding with abort still retires that word
    assign w_step = (r_state == ST_WRITE) && bus_ack;

    assign fifo_rd    = (r_state == ST_POP) && !fifo_empty && !abort;
    assign fifo_clear = r_fifo_clear;
    assign bus_req    = r_bus_req;
    assign bus_wdata  = r_wdata;
    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE);

    dmac_xfer_cnt #(
        .LEN_W     (LEN_W),
        .ADDR_STEP (ADDR_STEP)
    ) u_cnt (
        .clk         (clk),
        .rst_n       (rst),
        .i_load      (w_load),
        .i_load_addr (dst_addr),
        .i_load_len  (xfer_len),
        .i_load_inc  (addr_inc),
        .i_step      (w_step),
        .o_addr      (bus_addr),
        .o_count     (remaining),
        .o_last      (w_last)
    );

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_next = (xfer_len == '0) ? ST_DONE : ST_POP;
                    end
                end
                ST_POP: begin
                    if (!fifo_empty) begin
                        w_next = ST_LOAD;
                    end
                end
                ST_LOAD:  w_next = ST_WRITE;
                ST_WRITE: begin
                    if (bus_ack) begin
                        w_next = w_last ? ST_DONE : ST_POP;
                    end
                end
                ST_DONE:  w_next = ST_IDLE;
                default:  w_next = ST_IDLE;
            endcase
        end
    end

    // bus_req is a pure register of "next state is WRITE", so it cannot glitch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_bus_req    <= 1'b0;
            r_fifo_clear <= 1'b0;
            r_wdata      <= '0;
        end else begin
            r_state      <= w_next;
            r_bus_req    <= (w_next == ST_WRITE);
            r_fifo_clear <= abort;
            if (r_state == ST_LOAD) begin
                r_wdata <= fifo_rdata;
            end
        end
    end

endmodule
